// File: rtl/serial_word_transmitter_if.sv
// Handshake and 3-wire serial link bundle for serial_word_transmitter.
// The producer side uses the master modport; the transmitter uses the slave modport.
interface serial_word_transmitter_if #(
   parameter int DATA_WIDTH = 64
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  busy;
   logic                  transmission;
   logic                  clock;
   logic                  data;
   logic                  frame_done;

   modport master (
      output in_data, in_valid,
      input  in_ready, busy, transmission, clock, data, frame_done
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, busy, transmission, clock, data, frame_done
   );
endinterface

// File: rtl/serial_word_transmitter.sv
// Shifts one accepted word out on a transmission/clock/data link; optional even parity bit (SERIAL_TX_PARITY_EN).
// Latency: first bit on the line the cycle after accept; frame = bits*2*CLK_DIV cycles, then GAP_BITS idle bit periods.
// Backpressure: in_ready only in IDLE, so in_valid is held off for the whole frame plus gap.
module serial_word_transmitter #(
   parameter int DATA_WIDTH = 64,
   parameter int CLK_DIV    = 50,
   parameter int GAP_BITS   = 2,
   parameter int MSB_FIRST  = 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   serial_word_transmitter_if.slave  tx_if
);

   localparam int HCW     = $clog2(CLK_DIV + 1);
   localparam int BCW     = $clog2(DATA_WIDTH + 1);
   localparam int GAP_CYC = GAP_BITS * 2 * CLK_DIV;
   localparam int GCW     = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

   localparam logic [HCW-1:0] HC_LAST = HCW'(CLK_DIV - 1);
   localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_WIDTH - 1);
   localparam logic [GCW-1:0] GC_LAST = GCW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

`ifdef SERIAL_TX_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

   state_t                state_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [DATA_WIDTH-1:0] shreg_d;
   logic [HCW-1:0]        hcnt_q;
   logic [BCW-1:0]        bcnt_q;
   logic [GCW-1:0]        gcnt_q;
   logic                  in_ready_q;
   logic                  busy_q;
   logic                  trans_q;
   logic                  clock_q;
   logic                  data_q;
   logic                  done_q;
`ifdef SERIAL_TX_PARITY_EN
   logic                  par_q;
`endif

   logic first_bit;
   logic next_bit;
   logic half_end;
   logic bit_end;
   logic frame_end;

   always_comb begin
      shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
      next_bit  = (MSB_FIRST != 0) ? shreg_d[DATA_WIDTH-1] : shreg_d[0];
      first_bit = (MSB_FIRST != 0) ? tx_if.in_data[DATA_WIDTH-1] : tx_if.in_data[0];
      half_end  = (hcnt_q == HC_LAST);
      bit_end   = half_end && clock_q;
`ifdef SERIAL_TX_PARITY_EN
      frame_end = (state_q == PARITY) && bit_end;
`else
      frame_end = (state_q == SHIFT) && bit_end && (bcnt_q == BC_LAST);
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         shreg_q    <= '0;
         hcnt_q     <= '0;
         bcnt_q     <= '0;
         gcnt_q     <= '0;
         in_ready_q <= 1'b1;
         busy_q     <= 1'b0;
         trans_q    <= 1'b0;
         clock_q    <= 1'b0;
         data_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
         par_q      <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (tx_if.in_valid && in_ready_q) begin
                  state_q    <= SHIFT;
                  shreg_q    <= tx_if.in_data;
`ifdef SERIAL_TX_PARITY_EN
                  par_q      <= ^tx_if.in_data;
`endif
                  hcnt_q     <= '0;
                  bcnt_q     <= '0;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  trans_q    <= 1'b1;
                  clock_q    <= 1'b0;
                  data_q     <= first_bit;
               end
            end
`ifdef SERIAL_TX_PARITY_EN
            SHIFT, PARITY: begin
`else
            SHIFT: begin
`endif
               if (!half_end) begin
                  hcnt_q <= hcnt_q + 1'b1;
               end else begin
                  hcnt_q <= '0;
                  if (!clock_q) begin
                     clock_q <= 1'b1;
                  end else begin
                     // End of a bit: next bit goes out at the start of the new low phase.
                     clock_q <= 1'b0;
                     if (state_q == SHIFT && bcnt_q != BC_LAST) begin
                        bcnt_q  <= bcnt_q + 1'b1;
                        shreg_q <= shreg_d;
                        data_q  <= next_bit;
                     end
`ifdef SERIAL_TX_PARITY_EN
                     else if (state_q == SHIFT) begin
                        state_q <= PARITY;
                        data_q  <= par_q;
                     end
`endif
                  end
               end
            end
            GAP: begin
               if (gcnt_q == GC_LAST) begin
                  state_q    <= IDLE;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
               end else begin
                  gcnt_q <= gcnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase

         // Last high phase of the frame closes the envelope; this overrides the per-bit update above.
         if (frame_end) begin
            done_q  <= 1'b1;
            trans_q <= 1'b0;
            clock_q <= 1'b0;
            data_q  <= 1'b0;
            bcnt_q  <= '0;
            gcnt_q  <= '0;
            if (GAP_CYC == 0) begin
               state_q    <= IDLE;
               in_ready_q <= 1'b1;
               busy_q     <= 1'b0;
            end else begin
               state_q <= GAP;
            end
         end
      end
   end

   assign tx_if.in_ready     = in_ready_q;
   assign tx_if.busy         = busy_q;
   assign tx_if.transmission = trans_q;
   assign tx_if.clock        = clock_q;
   assign tx_if.data         = data_q;
   assign tx_if.frame_done   = done_q;

endmodule
